// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between two requesters using
//            valid/ready handshakes. Build option: ALU_ARB_FIXED_PRIO_EN
//            gives port 0 fixed priority instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_src1_0,
    input  logic [WIDTH-1:0] req_src1_1,
    input  logic [WIDTH-1:0] req_src2_0,
    input  logic [WIDTH-1:0] req_src2_1,
    input  logic [OPW-1:0]   req_op_0,
    input  logic [OPW-1:0]   req_op_1,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_0,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_src2;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_gid;
    logic             r_rsp_valid_0;
    logic             r_rsp_valid_1;
    logic             w_win;
    logic             w_grant;
    logic             w_rsp_take;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_win = ~req_valid_0;
`else
    logic r_last;

    // On a tie the port that was not granted most recently wins.
    assign w_win = (req_valid_0 && req_valid_1) ? ~r_last : req_valid_1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`endif

    assign w_rsp_take = r_gid ? rsp_ready_1 : rsp_ready_0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Reset is folded in so no handshake completes while held.
                if ((req_valid_0 || req_valid_1) && !rst) begin
                    w_grant     = 1'b1;
                    req_ready_0 = ~w_win;
                    req_ready_1 = w_win;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_take) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src1        <= '0;
            r_src2        <= '0;
            r_op          <= '0;
            r_gid         <= 1'b0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_rsp_valid_0 <= 1'b0;
            r_rsp_valid_1 <= 1'b0;
        end else begin
            if (w_grant) begin
                r_src1 <= w_win ? req_src1_1 : req_src1_0;
                r_src2 <= w_win ? req_src2_1 : req_src2_0;
                r_op   <= w_win ? req_op_1   : req_op_0;
                r_gid  <= w_win;
            end
            if (r_state == S_EXEC) begin
                r_result      <= alu_result;
                r_zero        <= alu_zero;
                r_rsp_valid_0 <= ~r_gid;
                r_rsp_valid_1 <= r_gid;
            end
            if ((r_state == S_RESP) && w_rsp_take) begin
                r_rsp_valid_0 <= 1'b0;
                r_rsp_valid_1 <= 1'b0;
            end
        end
    end

    assign alu_src1    = r_src1;
    assign alu_src2    = r_src2;
    assign alu_op      = r_op;
    assign rsp_result  = r_result;
    assign rsp_zero    = r_zero;
    assign rsp_valid_0 = r_rsp_valid_0;
    assign rsp_valid_1 = r_rsp_valid_1;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a transaction-level
//            reference model, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic             clk;
    logic             rst;
    logic             req_valid_0, req_valid_1;
    logic             req_ready_0, req_ready_1;
    logic [WIDTH-1:0] req_src1_0, req_src1_1, req_src2_0, req_src2_1;
    logic [OPW-1:0]   req_op_0, req_op_1;
    logic             rsp_valid_0, rsp_valid_1;
    logic             rsp_ready_0, rsp_ready_1;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic [WIDTH-1:0] alu_src1, alu_src2;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_src1_0(req_src1_0), .req_src1_1(req_src1_1),
        .req_src2_0(req_src2_0), .req_src2_1(req_src2_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, others yield 0.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [OPW-1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_src1, alu_src2, alu_op);
        alu_zero   = (alu_result == '0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, age counted in cycles.
    bit               busy;
    int               age;
    bit               gport;
    bit               m_last;
    logic [WIDTH-1:0] m_s1, m_s2, m_res;
    logic [OPW-1:0]   m_op;
    bit               m_zero;

    always @(negedge clk) begin
        bit win, er0, er1, ev0, ev1;
        if (rst) begin
            busy   = 0;
            age    = 0;
            m_last = 1;
            m_s1   = '0;
            m_s2   = '0;
            m_op   = '0;
            chk("rst_req_ready_0", req_ready_0, 0);
            chk("rst_req_ready_1", req_ready_1, 0);
            chk("rst_rsp_valid_0", rsp_valid_0, 0);
            chk("rst_rsp_valid_1", rsp_valid_1, 0);
            chk("rst_alu_src1", alu_src1, 0);
            chk("rst_alu_src2", alu_src2, 0);
            chk("rst_alu_op", alu_op, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_zero", rsp_zero, 0);
        end else begin
            if (busy) age++;
            er0 = 0; er1 = 0; ev0 = 0; ev1 = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
            win = !req_valid_0;
`else
            win = (req_valid_0 && req_valid_1) ? !m_last : req_valid_1;
`endif
            if (!busy) begin
                if (req_valid_0 || req_valid_1) begin
                    if (win) er1 = 1; else er0 = 1;
                end
            end else if (age >= 2) begin
                if (gport) ev1 = 1; else ev0 = 1;
            end
            chk("req_ready_0", req_ready_0, er0);
            chk("req_ready_1", req_ready_1, er1);
            chk("rsp_valid_0", rsp_valid_0, ev0);
            chk("rsp_valid_1", rsp_valid_1, ev1);
            chk("alu_src1", alu_src1, m_s1);
            chk("alu_src2", alu_src2, m_s2);
            chk("alu_op", alu_op, m_op);
            if (ev0 || ev1) begin
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_zero", rsp_zero, m_zero);
            end
            if (er0 || er1) begin
                busy   = 1;
                age    = 0;
                gport  = win;
                m_last = win;
                m_s1   = win ? req_src1_1 : req_src1_0;
                m_s2   = win ? req_src2_1 : req_src2_0;
                m_op   = win ? req_op_1 : req_op_0;
                m_res  = alu_fn(m_s1, m_s2, m_op);
                m_zero = (m_res == '0);
            end else if (busy && age >= 2 && (gport ? rsp_ready_1 : rsp_ready_0)) begin
                busy = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic new_op(output logic [WIDTH-1:0] s1, output logic [WIDTH-1:0] s2,
                          output logic [OPW-1:0] op);
        s1 = $urandom;
        s2 = ($urandom_range(0, 3) == 0) ? s1 : WIDTH'($urandom);
        op = OPW'($urandom_range(0, 15));
    endtask

    initial begin
        int k;
        bit gp [3];
        int gc [3];
        bit a0, a1;
        bit seen;
        rst = 1;
        req_valid_0 = 0; req_valid_1 = 0;
        req_src1_0 = '0; req_src1_1 = '0; req_src2_0 = '0; req_src2_1 = '0;
        req_op_0 = '0; req_op_1 = '0;
        rsp_ready_0 = 0; rsp_ready_1 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Single request: 5 + 3 on port 0
        req_valid_0 = 1; req_src1_0 = 5; req_src2_0 = 3; req_op_0 = 4'd0; rsp_ready_0 = 1;
        #1 chk("single_ready0", req_ready_0, 1);
        tick; req_valid_0 = 0;
        tick;
        #1;
        chk("single_rsp_valid0", rsp_valid_0, 1);
        chk("single_result", rsp_result, 8);
        chk("single_zero", rsp_zero, 0);
        tick; tick;

        // Tie from reset: grants alternate every 3 cycles
        rst = 1; tick; tick; rst = 0;
        new_op(req_src1_0, req_src2_0, req_op_0);
        new_op(req_src1_1, req_src2_1, req_op_1);
        req_valid_0 = 1; req_valid_1 = 1; rsp_ready_0 = 1; rsp_ready_1 = 1;
        k = 0;
        for (int c = 0; c < 9; c++) begin
            #1;
            a0 = req_ready_0; a1 = req_ready_1;
            if ((a0 || a1) && k < 3) begin
                gp[k] = a1; gc[k] = c; k++;
            end
            tick;
            if (a0) new_op(req_src1_0, req_src2_0, req_op_0);
            if (a1) new_op(req_src1_1, req_src2_1, req_op_1);
            if (c == 8) begin req_valid_0 = 0; req_valid_1 = 0; end
        end
        chk("tie_grant_count", k, 3);
        chk("tie_port_a", gp[0], 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("tie_port_b", gp[1], 0);
`else
        chk("tie_port_b", gp[1], 1);
`endif
        chk("tie_port_c", gp[2], 0);
        chk("tie_cycle_b", gc[1], 3);
        chk("tie_cycle_c", gc[2], 6);
        tick; tick;

        // Zero flag with back-pressure on port 1
        req_valid_1 = 1; req_src1_1 = 7; req_src2_1 = 7; req_op_1 = 4'd1;
        rsp_ready_1 = 0; rsp_ready_0 = 1;
        #1 chk("bp_ready1", req_ready_1, 1);
        tick;
        req_valid_1 = 0; req_valid_0 = 1; req_src1_0 = 1; req_src2_0 = 2; req_op_0 = 4'd0;
        #1 chk("bp_exec_ready0", req_ready_0, 0);
        tick;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid1", rsp_valid_1, 1);
            chk("bp_result", rsp_result, 0);
            chk("bp_zero", rsp_zero, 1);
            chk("bp_ready0_blocked", req_ready_0, 0);
            tick;
        end
        rsp_ready_1 = 1;
        #1 chk("bp_still_valid", rsp_valid_1, 1);
        tick;
        #1;
        chk("bp_ready0_after", req_ready_0, 1);
        chk("bp_rsp_valid1_clr", rsp_valid_1, 0);
        tick; req_valid_0 = 0;
        tick; tick; tick;

        // Reset asserted during EXEC
        req_valid_0 = 1; req_src1_0 = 9; req_src2_0 = 9; req_op_0 = 4'd0;
        #1 chk("rx_ready0", req_ready_0, 1);
        tick; req_valid_0 = 0;
        #2 rst = 1;
        #1;
        chk("rx_async_src1", alu_src1, 0);
        chk("rx_async_op", alu_op, 0);
        chk("rx_async_valid0", rsp_valid_0, 0);
        tick; rst = 0;
        tick; tick; tick; tick;
        chk("rx_no_rsp", rsp_valid_0, 0);

`ifdef ALU_ARB_FIXED_PRIO_EN
        // Port 0 continuously valid starves port 1 until it drops
        req_valid_0 = 1; req_valid_1 = 1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("fp_ready1_starved", req_ready_1, 0);
            a0 = req_ready_0;
            tick;
            if (a0) new_op(req_src1_0, req_src2_0, req_op_0);
        end
        req_valid_0 = 0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            #1;
            if (req_ready_1) seen = 1;
            tick;
        end
        chk("fp_port1_served", seen, 1);
        req_valid_1 = 0;
        tick; tick; tick;
`endif

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            a0 = req_valid_0 && req_ready_0;
            a1 = req_valid_1 && req_ready_1;
            tick;
            if (a0 || !req_valid_0) begin
                req_valid_0 = ($urandom_range(0, 3) != 0);
                new_op(req_src1_0, req_src2_0, req_op_0);
            end
            if (a1 || !req_valid_1) begin
                req_valid_1 = ($urandom_range(0, 3) != 0);
                new_op(req_src1_1, req_src2_1, req_op_1);
            end
            rsp_ready_0 = ($urandom_range(0, 2) != 0);
            rsp_ready_1 = ($urandom_range(0, 2) != 0);
        end
        req_valid_0 = 0; req_valid_1 = 0;
        tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters: port 0 is the execute stage and port 1 is the branch/address unit. The block accepts one operation at a time through a valid/ready handshake. It grants requesters round-robin, drives the ALU inputs from registered operands, and returns the registered `result`/`zero` to the granted requester through a valid/ready response. It sits between the pipeline control logic and the `alu` instance.

## Interface
- `WIDTH`, default 32: operand and result width. Must match the `alu` data width.
- `OPW`, default 4: ALU opcode width. Opcodes are the `ALU_*` defines.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `req_valid_0`, `req_valid_1`  in  1  requester i has an operation pending.
- `req_ready_0`, `req_ready_1`  out  1  requester i's operation is accepted this cycle.
- `req_src1_0`, `req_src1_1`  in  WIDTH  first operand, per requester.
- `req_src2_0`, `req_src2_1`  in  WIDTH  second operand, per requester.
- `req_op_0`, `req_op_1`  in  OPW  ALU opcode, per requester.
- `rsp_valid_0`, `rsp_valid_1`  out  1  result is available for requester i.
- `rsp_ready_0`, `rsp_ready_1`  in  1  requester i takes the result.
- `rsp_result`  out  WIDTH  shared result bus. Meaningful only while some `rsp_valid_i` is high.
- `rsp_zero`  out  1  shared zero flag.
- `alu_src1`, `alu_src2`  out  WIDTH  to the `alu` inputs `src1` and `src2`.
- `alu_op`  out  OPW  to the `alu` input `alu_op`.
- `alu_result`  in  WIDTH  from the `alu` output `result`.
- `alu_zero`  in  1  from the `alu` output `zero`.

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If any `req_valid_i` is high, pick the winner. Assert `req_ready_winner` combinationally in this cycle only.
  - Capture the winner's src1, src2 and op into the operand registers. Record the grant id. Go to EXEC.
  - If no request is valid, stay in IDLE.
- Round-robin pointer `last`:
  - Holds the most recently granted port.
  - If both ports are valid, grant the port that is not `last`. If only one is valid, grant it.
  - `last` updates on every grant.
- EXEC:
  - `alu_src1`, `alu_src2` and `alu_op` come from the operand registers.
  - Sample `alu_result` and `alu_zero` into the response registers. Go to RESP.
- RESP:
  - Assert `rsp_valid_gid`. Hold `rsp_result` and `rsp_zero` stable.
  - On `rsp_ready_gid` high, return to IDLE.
- `alu_*` outputs are always driven from the operand registers, never directly from request inputs. The ALU input path is therefore glitch-free and registered.
- No requests are accepted outside IDLE. `req_ready_*` is 0 in EXEC and RESP.
- A requester must hold `req_valid` and its operands stable until `req_ready` is seen.
- `rsp_ready` of the non-granted port is ignored.
- Arithmetic and widths are handled entirely by the `alu`. The arbiter passes the full WIDTH/OPW values unmodified.

## Timing
- Reset values:
  - State = IDLE, `last` = 1, so port 0 wins the first tie.
  - Operand registers = 0, so `alu_src1`/`alu_src2`/`alu_op` = 0.
  - Response registers = 0. All `req_ready_*` and `rsp_valid_*` = 0.
- Latency: accept in cycle N, EXEC in N+1, `rsp_valid` high from N+2.
- Throughput: one operation per 3 cycles when `rsp_ready` is held high.
- `rsp_valid_i` is a registered output. `req_ready_i` is combinational from `req_valid_*`, the state and `last`.
- Simultaneous requests in IDLE: exactly one `req_ready` is asserted. The loser keeps waiting.
- Response back-pressure: RESP is held indefinitely and no new request is granted until the response is taken.
- Reset asserted mid-operation: an immediate asynchronous return to reset values. The in-flight operation is dropped and no `rsp_valid` is produced for it.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Port 0 always wins ties (fixed priority).
  - The `last` register is not implemented.
- Not defined: round-robin as described above.

## Test plan
- Single request: port 0 sends src1=5, src2=3, op=`ALU_ADD`.
  - `req_ready_0` is high in the same cycle.
  - Two cycles later `rsp_valid_0`=1, `rsp_result`=8, `rsp_zero`=0.
- Tie, round-robin: both ports are valid from reset with `rsp_ready` held high.
  - Port 0 is served, then port 1, then port 0.
  - Each grant is 3 cycles apart. Results return to the matching port.
- Zero flag and back-pressure: port 1 sends `ALU_SUB` with 7, 7 and `rsp_ready_1`=0 for 5 cycles.
  - `rsp_valid_1` stays high with `rsp_result`=0, `rsp_zero`=1.
  - Port 0, valid throughout, gets no `req_ready` until the response is taken.
- Reset mid-EXEC: assert `rst` during EXEC.
  - All outputs return to reset values asynchronously.
  - No `rsp_valid` appears afterwards until a new request arrives.
- With `ALU_ARB_FIXED_PRIO_EN`: both ports are continuously valid.
  - Port 0 wins every arbitration and port 1 never gets `req_ready`.
  - Port 1 is served once port 0 drops `req_valid`.
